sigpulse_meas: RTL and testbench
================================

Name: sigpulse_meas

Overview:
- Receive-side counterpart of the `sigpulse` single-pulse generator.
- Samples an asynchronous pulse line, rejects glitches, and measures the active-pulse width in `io_clk` cycles, where "active" means the line differs from `io_defaultLevel`.
- Reports each result with a one-cycle `pulse_valid` strobe.
- Used to loop-check `sigpulse` outputs and to capture external trigger widths.

Parameters:
- `_RAM_WIDTH`, 32, width of the measured-width counter and of `io_pulseWidth`.
- `FILT_LEN`, 4, glitch-filter length in cycles (legal range 1..255); input levels held for fewer cycles than this are rejected.

Ports:
- `io_clk`  in  1  system clock, 100 MHz.
- `io_rst`  in  1  synchronous reset, active-high.
- `io_en`  in  1  level: arm measurement while high; low aborts and returns to idle.
- `io_pulseIn`  in  1  asynchronous pulse line under measurement.
- `io_defaultLevel`  in  1  idle level of `io_pulseIn`; sampled when arming.
- `io_pulseWidth`  out  `_RAM_WIDTH`  last measured width in cycles; held until the next result.
- `pulse_valid`  out  1  one-cycle strobe: `io_pulseWidth` and `io_overflow` updated.
- `io_overflow`  out  1  last result saturated; qualified by `pulse_valid`, held with `io_pulseWidth`.
- `io_busy`  out  1  high in states `MEASURE` and `WAIT_INACT`.

Behaviour:

Clocking and reset:
- Single clock domain; every register updates on the `io_clk` rising edge.
- `io_rst` high on an edge clears all state, including mid-measurement:
  - state = `IDLE`, synchronizer flops = 0, filtered level = 0, filter counter = 0, width counter = 0.
  - `io_pulseWidth` = 0, `pulse_valid` = 0, `io_overflow` = 0, `io_busy` = 0.
- No partial result is reported after reset.

Synchronizer:
- 2-flop synchronizer on `io_pulseIn` produces `s`.

Glitch filter:
- Filtered level `filt` and a counter `fc` of width `clog2(FILT_LEN+1)`.
- Each edge where `s == filt`: `fc` <= 0.
- Where `s != filt`: if `fc == FILT_LEN-1`, then `filt` <= `s` and `fc` <= 0; otherwise `fc` <= `fc`+1.
- Both edges are delayed equally, so pulse width is preserved for pulses of at least `FILT_LEN` cycles.

Active definition:
- `act = filt ^ dl`, where `dl` is `io_defaultLevel` latched on leaving `IDLE`.

State machine (states `IDLE`, `WAIT_INACT`, `ARMED`, `MEASURE`):
- `IDLE`: when `io_en`=1, latch `dl`. Go to `WAIT_INACT` if `act` (computed with the new `dl`) is 1, else go to `ARMED`. This prevents measuring a pulse already in progress.
- `WAIT_INACT`: go to `ARMED` when `act`=0.
- `ARMED`: when `act`=1, set width counter `wc` <= 1 and go to `MEASURE`.
- `MEASURE`:
  - While `act`=1: `wc` <= `wc`+1, saturating at 2^`_RAM_WIDTH`-1; on saturation set internal `ovf`.
  - When `act`=0: `io_pulseWidth` <= `wc`, `io_overflow` <= `ovf`, `pulse_valid` <= 1 for one cycle, clear `ovf`, go to `ARMED`.
- Continuous mode: every subsequent pulse is measured while `io_en` stays high.
- `io_en`=0 in any state goes to `IDLE` on the next edge. An in-flight measurement is discarded: no `pulse_valid`, outputs unchanged.
- `dl` is not re-sampled until the next `IDLE` exit; changing `io_defaultLevel` while armed has no effect.

Latency:
- Let edge k be the first edge at which `io_pulseIn` is sampled back at the default level. `pulse_valid` is registered high on edge k+`FILT_LEN`+2.
- The reported width equals the number of edges at which `io_pulseIn` was sampled active, exact for a clean input.

Boundary conditions:
- Pulse shorter than `FILT_LEN` cycles: ignored entirely, no strobe.
- Gap (inactive time) shorter than `FILT_LEN`: merged into one pulse.
- `io_en` falling on the same edge that would strobe: abort wins, no strobe.
- Saturation: `io_pulseWidth` = all-ones, `io_overflow` = 1.

Test Plan:
1. Reset, `io_defaultLevel`=1, `io_en`=1, drive `io_pulseIn` low for 100 cycles -> single `pulse_valid`, `io_pulseWidth`=100, `io_overflow`=0, strobe 6 cycles (`FILT_LEN`=4) after the return-high sample edge.
2. `io_defaultLevel`=0, two pulses of 3 and 7 cycles separated by 20 cycles -> the 3-cycle pulse is rejected; a single strobe with width 7.
3. `io_pulseIn` already active when `io_en` rises (pulse of 50, arm at cycle 20) -> no result for that pulse; the next 12-cycle pulse reports 12.
4. `_RAM_WIDTH`=8, 300-cycle pulse -> `io_pulseWidth`=255, `io_overflow`=1; next 10-cycle pulse -> 10, `io_overflow`=0.
5. Drop `io_en` at cycle 30 of a 60-cycle pulse, or assert `io_rst` mid-pulse -> no strobe. After reset, `io_pulseWidth`=0 and `io_busy`=0.
6. Loopback from `sigpulse` with `io_pulseWidth`=100, triggered twice -> two strobes, each reporting 100.

Source files
------------

// File: rtl/sigpulse_meas.sv
// rtl/sigpulse_meas.sv - glitch-filtered pulse-width measurement with one-cycle result strobe
module sigpulse_meas #(
  parameter int _RAM_WIDTH = 32,
  parameter int FILT_LEN   = 4
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  io_en,
  input  logic                  io_pulseIn,
  input  logic                  io_defaultLevel,
  output logic [_RAM_WIDTH-1:0] io_pulseWidth,
  output logic                  pulse_valid,
  output logic                  io_overflow,
  output logic                  io_busy
);

  localparam int FC_W = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0]       FC_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [FC_W-1:0]       FC_ONE  = FC_W'(1);
  localparam logic [_RAM_WIDTH-1:0] WC_MAX  = '1;
  localparam logic [_RAM_WIDTH-1:0] WC_ONE  = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_INACT = 2'd1,
    ARMED      = 2'd2,
    MEASURE    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic                    filt_q, filt_d;
  logic [FC_W-1:0]         fc_q, fc_d;
  logic                    dl_q, dl_d;
  logic [_RAM_WIDTH-1:0]   wc_q, wc_d;
  logic                    ovf_q, ovf_d;
  logic [_RAM_WIDTH-1:0]   width_q, width_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;
  logic                    act;

  // Two-flop synchronizer for the asynchronous pulse line
  always_comb begin
    sync1_d = io_pulseIn;
    sync2_d = sync1_q;
  end

  // Glitch filter: the filtered level only follows s after FILT_LEN consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fc_d   = fc_q;
    if (sync2_q == filt_q) begin
      fc_d = '0;
    end else if (fc_q == FC_LAST) begin
      filt_d = sync2_q;
      fc_d   = '0;
    end else begin
      fc_d = fc_q + FC_ONE;
    end
  end

  assign act = filt_q ^ dl_q;

  // Measurement FSM: next state, width counter and result registers; disarm beats a pending strobe
  always_comb begin
    state_d    = state_q;
    dl_d       = dl_q;
    wc_d       = wc_q;
    ovf_d      = ovf_q;
    width_d    = width_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    if (!io_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          dl_d    = io_defaultLevel;
          state_d = (filt_q ^ io_defaultLevel) ? WAIT_INACT : ARMED;
        end
        WAIT_INACT: begin
          if (!act) state_d = ARMED;
        end
        ARMED: begin
          if (act) begin
            wc_d    = WC_ONE;
            ovf_d   = 1'b0;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (act) begin
            if (wc_q == WC_MAX) ovf_d = 1'b1;
            else                wc_d  = wc_q + WC_ONE;
          end else begin
            width_d    = wc_q;
            overflow_d = ovf_q;
            valid_d    = 1'b1;
            ovf_d      = 1'b0;
            state_d    = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      fc_q       <= '0;
      dl_q       <= 1'b0;
      wc_q       <= '0;
      ovf_q      <= 1'b0;
      width_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      fc_q       <= fc_d;
      dl_q       <= dl_d;
      wc_q       <= wc_d;
      ovf_q      <= ovf_d;
      width_q    <= width_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign io_pulseWidth = width_q;
  assign pulse_valid   = valid_q;
  assign io_overflow   = overflow_q;
  assign io_busy       = (state_q == MEASURE) || (state_q == WAIT_INACT);

endmodule

// File: tb/tb_sigpulse_meas.sv
// tb/tb_sigpulse_meas.sv - directed table-driven bench for sigpulse_meas
module tb_sigpulse_meas;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pin;
  logic        def_lvl;
  logic [31:0] w32;
  logic        v32, o32, b32;
  logic [7:0]  w8;
  logic        v8, o8, b8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cnt32 = 0, cnt8 = 0;
  int last_cyc = 0;
  logic [31:0] last_w32;
  logic        last_o32;
  logic [7:0]  last_w8;
  logic        last_o8;

  always #5 clk = ~clk;

  sigpulse_meas #(._RAM_WIDTH(32), .FILT_LEN(4)) dut32 (
    .io_clk(clk), .io_rst(rst), .io_en(en), .io_pulseIn(pin), .io_defaultLevel(def_lvl),
    .io_pulseWidth(w32), .pulse_valid(v32), .io_overflow(o32), .io_busy(b32)
  );

  sigpulse_meas #(._RAM_WIDTH(8), .FILT_LEN(4)) dut8 (
    .io_clk(clk), .io_rst(rst), .io_en(en), .io_pulseIn(pin), .io_defaultLevel(def_lvl),
    .io_pulseWidth(w8), .pulse_valid(v8), .io_overflow(o8), .io_busy(b8)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v32) begin
      cnt32    <= cnt32 + 1;
      last_w32 <= w32;
      last_o32 <= o32;
      last_cyc <= cyc;
    end
    if (v8) begin
      cnt8    <= cnt8 + 1;
      last_w8 <= w8;
      last_o8 <= o8;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input longint act_v, input longint exp_v);
    checks++;
    if (act_v != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end
  endtask

  task automatic rearm(input logic d);
    en = 1'b0;
    tick(2);
    def_lvl = d;
    pin = d;
    tick(8);
    en = 1'b1;
    tick(4);
  endtask

  typedef struct {
    logic        dl;
    int          len;
    int          exp_cnt;
    int          exp_w32;
    int          exp_w8;
    logic        exp_o8;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int c32, c8, n_ret;
    vecs[0] = '{1'b0, 3,   0, 0,   0,   1'b0};
    vecs[1] = '{1'b0, 7,   1, 7,   7,   1'b0};
    vecs[2] = '{1'b1, 4,   1, 4,   4,   1'b0};
    vecs[3] = '{1'b0, 1,   0, 0,   0,   1'b0};
    vecs[4] = '{1'b1, 300, 1, 300, 255, 1'b1};
    vecs[5] = '{1'b0, 10,  1, 10,  10,  1'b0};
    vecs[6] = '{1'b1, 255, 1, 255, 255, 1'b0};
    vecs[7] = '{1'b0, 256, 1, 256, 255, 1'b1};

    rst = 1'b1; en = 1'b0; pin = 1'b1; def_lvl = 1'b1;
    tick(3);
    check("reset_width", w32, 0);
    check("reset_valid", v32, 0);
    check("reset_ovf", o32, 0);
    check("reset_busy", b32, 0);
    rst = 1'b0;
    en = 1'b1;
    tick(12);
    check("armed_not_busy", b32, 0);

    // default high, 100-cycle low pulse, strobe latency
    c32 = cnt32;
    pin = 1'b0;
    tick(50);
    check("measure_busy", b32, 1);
    tick(50);
    pin = 1'b1;
    n_ret = cyc;
    tick(15);
    check("t1_count", cnt32 - c32, 1);
    check("t1_width", last_w32, 100);
    check("t1_ovf", last_o32, 0);
    check("t1_latency", last_cyc, n_ret + 7);

    // table: single pulse per vector, both counter widths
    foreach (vecs[i]) begin
      rearm(vecs[i].dl);
      c32 = cnt32; c8 = cnt8;
      pin = ~vecs[i].dl;
      tick(vecs[i].len);
      pin = vecs[i].dl;
      tick(15);
      check($sformatf("vec%0d_cnt32", i), cnt32 - c32, vecs[i].exp_cnt);
      check($sformatf("vec%0d_cnt8", i), cnt8 - c8, vecs[i].exp_cnt);
      if (vecs[i].exp_cnt == 1) begin
        check($sformatf("vec%0d_w32", i), last_w32, vecs[i].exp_w32);
        check($sformatf("vec%0d_o32", i), last_o32, 0);
        check($sformatf("vec%0d_w8", i), last_w8, vecs[i].exp_w8);
        check($sformatf("vec%0d_o8", i), last_o8, vecs[i].exp_o8);
      end
    end

    // short gap merges two pulses
    rearm(1'b0);
    c32 = cnt32;
    pin = 1'b1; tick(10); pin = 1'b0; tick(2); pin = 1'b1; tick(10); pin = 1'b0;
    tick(15);
    check("merge_cnt", cnt32 - c32, 1);
    check("merge_width", last_w32, 22);

    // pulse already active when armed is skipped
    en = 1'b0; def_lvl = 1'b0; pin = 1'b1;
    tick(20);
    c32 = cnt32;
    en = 1'b1;
    tick(3);
    check("wait_inact_busy", b32, 1);
    tick(27);
    pin = 1'b0;
    tick(20);
    check("inprog_cnt", cnt32 - c32, 0);
    pin = 1'b1; tick(12); pin = 1'b0;
    tick(15);
    check("after_inprog_cnt", cnt32 - c32, 1);
    check("after_inprog_w", last_w32, 12);

    // default level changed while armed is ignored
    def_lvl = 1'b1;
    tick(20);
    check("dl_hold_cnt", cnt32 - c32, 1);
    pin = 1'b1; tick(8); pin = 1'b0;
    tick(15);
    check("dl_hold_cnt2", cnt32 - c32, 2);
    check("dl_hold_w", last_w32, 8);

    // abort mid-pulse
    rearm(1'b0);
    c32 = cnt32;
    pin = 1'b1; tick(30);
    en = 1'b0; tick(30);
    pin = 1'b0; tick(15);
    check("abort_cnt", cnt32 - c32, 0);
    check("abort_width_held", w32, 8);
    check("abort_busy", b32, 0);

    // disarm on the strobe edge wins
    rearm(1'b0);
    c32 = cnt32;
    pin = 1'b1; tick(20);
    pin = 1'b0; tick(6);
    en = 1'b0; tick(10);
    check("abort_strobe_edge_cnt", cnt32 - c32, 0);

    // reset mid-pulse
    rearm(1'b0);
    c32 = cnt32;
    pin = 1'b1; tick(30);
    rst = 1'b1; tick(2);
    check("rst_mid_width", w32, 0);
    check("rst_mid_busy", b32, 0);
    check("rst_mid_ovf", o32, 0);
    rst = 1'b0;
    pin = 1'b0; tick(20);
    check("rst_mid_cnt", cnt32 - c32, 0);

    // two back-to-back 100-cycle pulses in continuous mode
    rearm(1'b1);
    c32 = cnt32;
    pin = 1'b0; tick(100); pin = 1'b1; tick(30);
    check("loop1_w", last_w32, 100);
    pin = 1'b0; tick(100); pin = 1'b1; tick(30);
    check("loop_cnt", cnt32 - c32, 2);
    check("loop2_w", last_w32, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
